// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_MEMWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic stall;
    logic bubble;
  } pipe_ctl_t;

  localparam int MEM_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking precedence over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use, redirect and memory-wait hazards,
// memory-wait watchdog and saturating hazard counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDRW   = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [REG_ADDRW-1:0] i_idu_rs1id,
  input  logic [REG_ADDRW-1:0] i_idu_rs2id,
  input  logic                 i_idu_rs1en,
  input  logic                 i_idu_rs2en,
  input  logic [REG_ADDRW-1:0] i_exu_rdid,
  input  logic                 i_exu_rdwen,
  input  logic                 i_exu_lden,
  input  logic                 i_exu_jmp,
  input  logic                 i_lsu_req,
  input  logic                 i_lsu_ack,
  input  logic                 i_cnt_clr,
  output logic                 o_pc_wen,
  output logic                 o_ifid_stall,
  output logic                 o_ifid_bubble,
  output logic                 o_idex_stall,
  output logic                 o_idex_bubble,
  output logic                 o_exls_stall,
  output logic                 o_exls_bubble,
  output logic                 o_lswb_bubble,
  output logic                 o_lsu_busy,
  output logic                 o_mem_timeout,
  output logic                 o_mem_err,
  output logic [CNT_W-1:0]     o_cnt_lduse,
  output logic [CNT_W-1:0]     o_cnt_flush,
  output logic [CNT_W-1:0]     o_cnt_memwait
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          err_reg;
  logic          memwait, lduse, apply_jmp, apply_lduse;
  pipe_ctl_t     ifid, idex, exls;

  assign memwait = i_lsu_req & ~i_lsu_ack;
  assign lduse   = i_exu_lden & i_exu_rdwen & (i_exu_rdid != '0) &
                   ((i_idu_rs1en & (i_idu_rs1id == i_exu_rdid)) |
                    (i_idu_rs2en & (i_idu_rs2id == i_exu_rdid)));
  assign apply_jmp   = ~memwait & i_exu_jmp;
  assign apply_lduse = ~memwait & ~i_exu_jmp & lduse;

  always_comb begin
    o_pc_wen      = 1'b1;
    ifid          = '0;
    idex          = '0;
    exls          = '0;
    o_lswb_bubble = 1'b0;
    if (memwait) begin
      o_pc_wen      = 1'b0;
      ifid.stall    = 1'b1;
      idex.stall    = 1'b1;
      exls.stall    = 1'b1;
      o_lswb_bubble = 1'b1;
    end else if (i_exu_jmp) begin
      ifid.bubble = 1'b1;
      idex.bubble = 1'b1;
    end else if (lduse) begin
      o_pc_wen    = 1'b0;
      ifid.stall  = 1'b1;
      idex.bubble = 1'b1;
    end
  end

  assign o_ifid_stall  = ifid.stall;
  assign o_ifid_bubble = ifid.bubble;
  assign o_idex_stall  = idex.stall;
  assign o_idex_bubble = idex.bubble;
  assign o_exls_stall  = exls.stall;
  assign o_exls_bubble = exls.bubble;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RUN:     if (i_lsu_req && !i_lsu_ack) state_next = S_MEMWAIT;
      S_MEMWAIT: if (i_lsu_ack || !i_lsu_req) state_next = S_RUN;
      default:   state_next = S_RUN;
    endcase
  end

  // Timer counts every wait cycle including the one that enters S_MEMWAIT,
  // so it reads N-1 during the N-th wait cycle; it parks at MEM_TIMEOUT so
  // the pulse fires only once per wait.
  always_comb begin
    timer_next = '0;
    if (memwait) begin
      timer_next = (timer_reg == TW'(MEM_TIMEOUT)) ? timer_reg : timer_reg + TW'(1);
    end
  end

  assign o_mem_timeout = memwait & (timer_reg == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_RUN;
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (i_cnt_clr)          err_reg <= 1'b0;
      else if (o_mem_timeout) err_reg <= 1'b1;
    end
  end

  assign o_lsu_busy = (state_reg == S_MEMWAIT);
  assign o_mem_err  = err_reg;

  sat_counter #(.W(CNT_W)) u_cnt_lduse (
    .clk(i_clk), .rst_n(i_rst_n), .inc(apply_lduse), .clr(i_cnt_clr), .cnt(o_cnt_lduse)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk(i_clk), .rst_n(i_rst_n), .inc(apply_jmp), .clr(i_cnt_clr), .cnt(o_cnt_flush)
  );

  sat_counter #(.W(CNT_W)) u_cnt_memwait (
    .clk(i_clk), .rst_n(i_rst_n), .inc(memwait), .clr(i_cnt_clr), .cnt(o_cnt_memwait)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=8).
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [RW-1:0] i_idu_rs1id, i_idu_rs2id, i_exu_rdid;
  logic          i_idu_rs1en, i_idu_rs2en, i_exu_rdwen, i_exu_lden, i_exu_jmp;
  logic          i_lsu_req, i_lsu_ack, i_cnt_clr;
  logic          o_pc_wen, o_ifid_stall, o_ifid_bubble, o_idex_stall, o_idex_bubble;
  logic          o_exls_stall, o_exls_bubble, o_lswb_bubble;
  logic          o_lsu_busy, o_mem_timeout, o_mem_err;
  logic [CW-1:0] o_cnt_lduse, o_cnt_flush, o_cnt_memwait;
  logic [7:0]    ctl;

  int checks = 0;
  int errors = 0;

  // Control vector: {pc_wen, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
  // exls_stall, exls_bubble, lswb_bubble}
  localparam logic [7:0] C_RUN   = 8'h80;
  localparam logic [7:0] C_LDUSE = 8'h48;
  localparam logic [7:0] C_JMP   = 8'hA8;
  localparam logic [7:0] C_WAIT  = 8'h55;

  assign ctl = {o_pc_wen, o_ifid_stall, o_ifid_bubble, o_idex_stall, o_idex_bubble,
                o_exls_stall, o_exls_bubble, o_lswb_bubble};

  always #5 i_clk = ~i_clk;

  pipe_hazard_ctrl #(.REG_ADDRW(RW), .CNT_W(CW), .MEM_TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_idu_rs1id(i_idu_rs1id), .i_idu_rs2id(i_idu_rs2id),
    .i_idu_rs1en(i_idu_rs1en), .i_idu_rs2en(i_idu_rs2en),
    .i_exu_rdid(i_exu_rdid), .i_exu_rdwen(i_exu_rdwen), .i_exu_lden(i_exu_lden),
    .i_exu_jmp(i_exu_jmp), .i_lsu_req(i_lsu_req), .i_lsu_ack(i_lsu_ack),
    .i_cnt_clr(i_cnt_clr), .o_pc_wen(o_pc_wen),
    .o_ifid_stall(o_ifid_stall), .o_ifid_bubble(o_ifid_bubble),
    .o_idex_stall(o_idex_stall), .o_idex_bubble(o_idex_bubble),
    .o_exls_stall(o_exls_stall), .o_exls_bubble(o_exls_bubble),
    .o_lswb_bubble(o_lswb_bubble), .o_lsu_busy(o_lsu_busy),
    .o_mem_timeout(o_mem_timeout), .o_mem_err(o_mem_err),
    .o_cnt_lduse(o_cnt_lduse), .o_cnt_flush(o_cnt_flush), .o_cnt_memwait(o_cnt_memwait)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_idu_rs1id = '0; i_idu_rs2id = '0; i_exu_rdid = '0;
    i_idu_rs1en = 0;  i_idu_rs2en = 0;  i_exu_rdwen = 0; i_exu_lden = 0;
    i_exu_jmp = 0;    i_lsu_req = 0;    i_lsu_ack = 0;   i_cnt_clr = 0;
  endtask

  task automatic set_lduse(input logic [RW-1:0] rd);
    i_exu_lden = 1; i_exu_rdwen = 1; i_exu_rdid = rd;
    i_idu_rs2en = 1; i_idu_rs2id = rd;
  endtask

  task automatic clear_counters();
    idle();
    i_cnt_clr = 1;
    tick();
    i_cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 0;
    #2;
    checks++;
    if (ctl !== C_RUN || o_lsu_busy !== 1'b0 || o_mem_err !== 1'b0 || o_mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%h busy=%b err=%b to=%b required ctl=%h busy=0 err=0 to=0",
               ctl, o_lsu_busy, o_mem_err, o_mem_timeout, C_RUN);
    end
    checks++;
    if ({o_cnt_lduse, o_cnt_flush, o_cnt_memwait} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got %h/%h/%h required 0/0/0", o_cnt_lduse, o_cnt_flush, o_cnt_memwait);
    end
    @(negedge i_clk);
    i_rst_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_lduse();
    clear_counters();
    set_lduse(5'd5);
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin
      errors++; $display("FAIL lduse_ctl: got %h required %h", ctl, C_LDUSE);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_cnt_lduse !== 4'd1 || ctl !== C_RUN) begin
      errors++; $display("FAIL lduse_after: cnt=%0d ctl=%h required cnt=1 ctl=%h", o_cnt_lduse, ctl, C_RUN);
    end
    set_lduse(5'd0);
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL lduse_rd0: got %h required %h", ctl, C_RUN);
    end
    tick();
    idle();
    i_exu_lden = 1; i_exu_rdwen = 0; i_exu_rdid = 5'd7; i_idu_rs1en = 1; i_idu_rs1id = 5'd7;
    #1;
    checks++;
    if (ctl !== C_RUN || o_cnt_lduse !== 4'd1) begin
      errors++; $display("FAIL lduse_nowen: ctl=%h cnt=%0d required ctl=%h cnt=1", ctl, o_cnt_lduse, C_RUN);
    end
    i_exu_rdwen = 1;
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin
      errors++; $display("FAIL lduse_rs1: got %h required %h", ctl, C_LDUSE);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_cnt_lduse !== 4'd2) begin
      errors++; $display("FAIL lduse_cnt2: got %0d required 2", o_cnt_lduse);
    end
    $display("test_lduse done");
  endtask

  task automatic test_jmp_lduse();
    clear_counters();
    set_lduse(5'd9);
    i_exu_jmp = 1;
    #1;
    checks++;
    if (ctl !== C_JMP) begin
      errors++; $display("FAIL jmp_ctl: got %h required %h", ctl, C_JMP);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_cnt_flush !== 4'd1 || o_cnt_lduse !== 4'd0) begin
      errors++; $display("FAIL jmp_cnts: flush=%0d lduse=%0d required flush=1 lduse=0", o_cnt_flush, o_cnt_lduse);
    end
    $display("test_jmp_lduse done");
  endtask

  task automatic test_memwait();
    logic [7:0] exp_ctl;
    clear_counters();
    for (int k = 1; k <= 4; k++) begin
      i_lsu_req = 1; i_lsu_ack = (k == 4); i_exu_jmp = 1;
      #1;
      exp_ctl = (k < 4) ? C_WAIT : C_JMP;
      checks++;
      if (ctl !== exp_ctl || o_lsu_busy !== (k >= 2) || o_mem_timeout !== 1'b0) begin
        errors++;
        $display("FAIL memwait_cycle%0d: ctl=%h busy=%b to=%b required ctl=%h busy=%b to=0",
                 k, ctl, o_lsu_busy, o_mem_timeout, exp_ctl, (k >= 2));
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (o_lsu_busy !== 1'b0 || o_cnt_memwait !== 4'd3 || o_cnt_flush !== 4'd1 || ctl !== C_RUN) begin
      errors++;
      $display("FAIL memwait_after: busy=%b memwait=%0d flush=%0d ctl=%h required busy=0 memwait=3 flush=1 ctl=%h",
               o_lsu_busy, o_cnt_memwait, o_cnt_flush, ctl, C_RUN);
    end
    $display("test_memwait done");
  endtask

  task automatic test_timeout();
    idle();
    for (int k = 1; k <= 10; k++) begin
      i_lsu_req = 1;
      #1;
      checks++;
      if (o_mem_timeout !== (k == 8) || o_mem_err !== (k >= 9) || ctl !== C_WAIT) begin
        errors++;
        $display("FAIL timeout_cycle%0d: to=%b err=%b ctl=%h required to=%b err=%b ctl=%h",
                 k, o_mem_timeout, o_mem_err, ctl, (k == 8), (k >= 9), C_WAIT);
      end
      tick();
    end
    idle();
    tick();
    checks++;
    if (o_mem_err !== 1'b1 || o_mem_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: err=%b to=%b required err=1 to=0", o_mem_err, o_mem_timeout);
    end
    clear_counters();
    checks++;
    if (o_mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clr: err=%b required 0", o_mem_err);
    end
    for (int k = 1; k <= 8; k++) begin
      i_lsu_req = 1; i_lsu_ack = (k == 8);
      #1;
      checks++;
      if (o_mem_timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_ack_suppress%0d: to=%b required 0", k, o_mem_timeout);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (o_mem_err !== 1'b0 || o_lsu_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_ack_after: err=%b busy=%b required 0 0", o_mem_err, o_lsu_busy);
    end
    $display("test_timeout done");
  endtask

  task automatic test_back_to_back();
    clear_counters();
    set_lduse(5'd3);
    i_lsu_req = 1; i_lsu_ack = 1;
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin
      errors++; $display("FAIL b2b_ackld: got %h required %h", ctl, C_LDUSE);
    end
    tick();
    idle();
    i_exu_jmp = 1;
    #1;
    checks++;
    if (o_lsu_busy !== 1'b0 || ctl !== C_JMP || o_cnt_lduse !== 4'd1) begin
      errors++;
      $display("FAIL b2b_jmp: busy=%b ctl=%h lduse=%0d required busy=0 ctl=%h lduse=1", o_lsu_busy, ctl, o_cnt_lduse, C_JMP);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o_cnt_flush !== 4'd1 || o_cnt_memwait !== 4'd0) begin
      errors++; $display("FAIL b2b_cnts: flush=%0d memwait=%0d required 1 0", o_cnt_flush, o_cnt_memwait);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    idle();
    i_lsu_req = 1;
    tick();
    checks++;
    if (o_lsu_busy !== 1'b1 || o_cnt_memwait === 4'd0) begin
      errors++; $display("FAIL arst_pre: busy=%b memwait=%0d required busy=1 memwait!=0", o_lsu_busy, o_cnt_memwait);
    end
    #2;
    i_rst_n = 0;
    #1;
    checks++;
    if (o_lsu_busy !== 1'b0 || {o_cnt_lduse, o_cnt_flush, o_cnt_memwait} !== '0 || o_mem_err !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: busy=%b cnts=%h/%h/%h err=%b required all 0",
               o_lsu_busy, o_cnt_lduse, o_cnt_flush, o_cnt_memwait, o_mem_err);
    end
    i_lsu_req = 0;
    @(negedge i_clk);
    i_rst_n = 1;
    #1;
    checks++;
    if (ctl !== C_RUN || o_lsu_busy !== 1'b0) begin
      errors++; $display("FAIL arst_release: ctl=%h busy=%b required ctl=%h busy=0", ctl, o_lsu_busy, C_RUN);
    end
    tick();
    $display("test_async_reset done");
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 20; i++) begin
      set_lduse(5'd12);
      tick();
      if (i == 13) begin
        checks++;
        if (o_cnt_lduse !== 4'd14) begin
          errors++; $display("FAIL sat_mid: got %0d required 14", o_cnt_lduse);
        end
      end
    end
    checks++;
    if (o_cnt_lduse !== 4'd15) begin
      errors++; $display("FAIL sat_top: got %0d required 15", o_cnt_lduse);
    end
    i_cnt_clr = 1;
    tick();
    idle();
    checks++;
    if (o_cnt_lduse !== 4'd0) begin
      errors++; $display("FAIL sat_clr_prio: got %0d required 0", o_cnt_lduse);
    end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_lduse();
    test_jmp_lduse();
    test_memwait();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
